mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory controller port between the icache and dcache miss interfaces of the core; sits between the core and the memory controller.
- Accepts one block request at a time from either cache and arbitrates round-robin.
- Registers the winning request and drives it downstream until the controller accepts it.
- Routes the response back to the owning cache; writes optionally complete without a response.

Parameters:
BLOCK_ADDR_W, 26, width of main-memory block address
BLOCK_DATA_W, 512, width of one cache block of data
WRITE_RESP, 0, 1: writes wait for mem_resp_valid; 0: writes complete on the mem_req handshake

Ports:
clk  in  1  clock
rst_aL  in  1  synchronous active-low reset
icache_req_valid  in  1  icache read request
icache_req_block_addr  in  BLOCK_ADDR_W  icache block address
icache_req_ready  out  1  request accepted this cycle
icache_resp_valid  out  1  icache fill data valid
icache_resp_block_data  out  BLOCK_DATA_W  icache fill data
dcache_req_valid  in  1  dcache request
dcache_req_type  in  1  0 read, 1 write
dcache_req_block_addr  in  BLOCK_ADDR_W  dcache block address
dcache_req_block_data  in  BLOCK_DATA_W  writeback data
dcache_req_ready  out  1  request accepted this cycle
dcache_resp_valid  out  1  dcache response valid
dcache_resp_block_data  out  BLOCK_DATA_W  dcache fill data
mem_req_valid  out  1  downstream request valid
mem_req_type  out  1  0 read, 1 write
mem_req_block_addr  out  BLOCK_ADDR_W  downstream address
mem_req_block_data  out  BLOCK_DATA_W  downstream write data
mem_req_ready  in  1  controller accepts request
mem_resp_valid  in  1  controller response valid
mem_resp_block_data  in  BLOCK_DATA_W  controller response data
busy  out  1  state != IDLE
owner  out  1  current/last grantee, 0 icache, 1 dcache

Behaviour:
- All state registers update on posedge clk. rst_aL=0 at an edge forces the reset state regardless of activity; an in-flight request is dropped without a response.
- Reset state: IDLE; last_grant=0 (icache), so dcache wins the first tie; request register cleared; owner=0.
- Reset values of outputs: all valid/ready outputs 0; busy=0; data outputs 0.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - If exactly one cache requests, that cache is granted.
  - If both request, the cache other than last_grant is granted.
  - Grant: the granted *_req_ready is asserted combinationally in that cycle (at most one ready high). Addr/type/data are latched; icache type is forced to 0. owner and last_grant are updated. Next state is ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - mem_req_valid=1 and the mem_req_* outputs come from the register, stable until handshake.
  - On mem_req_ready=1: if a write and WRITE_RESP=0, go to IDLE; otherwise go to WAIT_RESP.
  - On mem_req_ready=0: hold.
- WAIT_RESP:
  - On mem_resp_valid=1: the owner's *_resp_valid is asserted in the same cycle (combinational). mem_resp_block_data is passed to the owner's resp_block_data. Next state is IDLE.
  - The non-owner's resp_valid is never asserted.
- mem_resp_valid in IDLE or ISSUE is ignored and not forwarded.
- Upstream ready is high only in IDLE, so each cache sees at most one outstanding request. Requesters must hold valid/addr/data until ready.
- Latency:
  - accept at cycle N → mem_req_valid at N+1.
  - mem_req_ready at M → earliest response forwarded at M+1.
  - Response at cycle R → next accept at R+1 (one cycle of IDLE).
- mem_req_valid is deasserted in the cycle after the handshake; a request is never issued twice.
- resp_block_data outputs are don't-care when the corresponding resp_valid=0; the bench checks them only when valid.
- Fetch redirects/flushes do not cancel transactions; every accepted read receives its response.

Test Plan:
- Single icache read, addr=0x0000123, mem_req_ready at first ISSUE cycle, resp 3 cycles later data=0xA5.. → icache_req_ready 1 cycle; mem_req_type=0, addr=0x0000123; icache_resp_valid for 1 cycle with 0xA5..; dcache_resp_valid stays 0.
- Both caches request in the same cycle after reset → dcache granted first; icache is granted in the cycle after dcache completes; a third simultaneous pair after that grants dcache again (alternation).
- dcache write, addr=0x3FF, data=0xDEADBEEF.., WRITE_RESP=0 → one mem request with type=1 and data matching; returns to IDLE the cycle after mem_req_ready; no resp_valid. Repeat with WRITE_RESP=1 → completes only on mem_resp_valid, with dcache_resp_valid pulsed.
- Backpressure: mem_req_ready low for 5 cycles → mem_req_valid/addr/data stay stable for 6 cycles; both upstream readys stay 0; dcache request arriving meanwhile is not accepted until after completion.
- Spurious mem_resp_valid in IDLE and during ISSUE → no resp_valid on either cache; state unchanged.
- rst_aL=0 for 1 cycle while in WAIT_RESP → next cycle IDLE, busy=0; later mem_resp_valid is ignored; a subsequent tie grants dcache.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the memory controller port between the icache and dcache miss paths.
// One block request in flight at a time; the winning request is registered and held until accepted.
module mem_port_arbiter #(
  parameter int unsigned BLOCK_ADDR_W = 26,
  parameter int unsigned BLOCK_DATA_W = 512,
  parameter bit          WRITE_RESP   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_aL,
  input  logic                    icache_req_valid,
  input  logic [BLOCK_ADDR_W-1:0] icache_req_block_addr,
  output logic                    icache_req_ready,
  output logic                    icache_resp_valid,
  output logic [BLOCK_DATA_W-1:0] icache_resp_block_data,
  input  logic                    dcache_req_valid,
  input  logic                    dcache_req_type,
  input  logic [BLOCK_ADDR_W-1:0] dcache_req_block_addr,
  input  logic [BLOCK_DATA_W-1:0] dcache_req_block_data,
  output logic                    dcache_req_ready,
  output logic                    dcache_resp_valid,
  output logic [BLOCK_DATA_W-1:0] dcache_resp_block_data,
  output logic                    mem_req_valid,
  output logic                    mem_req_type,
  output logic [BLOCK_ADDR_W-1:0] mem_req_block_addr,
  output logic [BLOCK_DATA_W-1:0] mem_req_block_data,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [BLOCK_DATA_W-1:0] mem_resp_block_data,
  output logic                    busy,
  output logic                    owner
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    type_q, type_d;
  logic [BLOCK_ADDR_W-1:0] addr_q, addr_d;
  logic [BLOCK_DATA_W-1:0] data_q, data_d;
  logic                    grant_d_c;

  // dcache wins when alone, or on a tie when the icache was granted last
  assign grant_d_c = dcache_req_valid && (!icache_req_valid || !owner_q);

  always_comb begin
    state_d           = state_q;
    owner_d           = owner_q;
    type_d            = type_q;
    addr_d            = addr_q;
    data_d            = data_q;
    icache_req_ready  = 1'b0;
    dcache_req_ready  = 1'b0;
    icache_resp_valid = 1'b0;
    dcache_resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_aL) begin
          if (grant_d_c) begin
            dcache_req_ready = 1'b1;
            owner_d          = 1'b1;
            type_d           = dcache_req_type;
            addr_d           = dcache_req_block_addr;
            data_d           = dcache_req_block_data;
            state_d          = ISSUE;
          end else if (icache_req_valid) begin
            icache_req_ready = 1'b1;
            owner_d          = 1'b0;
            type_d           = 1'b0;
            addr_d           = icache_req_block_addr;
            data_d           = '0;
            state_d          = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = (type_q && !WRITE_RESP) ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid && rst_aL) begin
          icache_resp_valid = !owner_q;
          dcache_resp_valid = owner_q;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      type_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign mem_req_valid      = (state_q == ISSUE);
  assign mem_req_type       = type_q;
  assign mem_req_block_addr = addr_q;
  assign mem_req_block_data = data_q;
  assign busy               = (state_q != IDLE);
  assign owner              = owner_q;

  // Response data is zeroed toward the cache that is not being answered
  assign icache_resp_block_data = icache_resp_valid ? mem_resp_block_data : '0;
  assign dcache_resp_block_data = dcache_resp_valid ? mem_resp_block_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (writes complete on handshake / on response)
// share one stimulus stream and are checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic         clk, rst_aL;
  logic         iv, dv, dtype, mready, rvalid;
  logic [25:0]  ia, da;
  logic [511:0] dd, rdata;

  logic         i_rdy[2], d_rdy[2], i_rv[2], d_rv[2], m_v[2], m_t[2], bsy[2], own[2];
  logic [25:0]  m_a[2];
  logic [511:0] i_rd[2], d_rd[2], m_d[2];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.BLOCK_ADDR_W(26), .BLOCK_DATA_W(512), .WRITE_RESP(1'b0)) dut0 (
    .clk(clk), .rst_aL(rst_aL),
    .icache_req_valid(iv), .icache_req_block_addr(ia), .icache_req_ready(i_rdy[0]),
    .icache_resp_valid(i_rv[0]), .icache_resp_block_data(i_rd[0]),
    .dcache_req_valid(dv), .dcache_req_type(dtype), .dcache_req_block_addr(da),
    .dcache_req_block_data(dd), .dcache_req_ready(d_rdy[0]),
    .dcache_resp_valid(d_rv[0]), .dcache_resp_block_data(d_rd[0]),
    .mem_req_valid(m_v[0]), .mem_req_type(m_t[0]), .mem_req_block_addr(m_a[0]),
    .mem_req_block_data(m_d[0]), .mem_req_ready(mready),
    .mem_resp_valid(rvalid), .mem_resp_block_data(rdata),
    .busy(bsy[0]), .owner(own[0]));

  mem_port_arbiter #(.BLOCK_ADDR_W(26), .BLOCK_DATA_W(512), .WRITE_RESP(1'b1)) dut1 (
    .clk(clk), .rst_aL(rst_aL),
    .icache_req_valid(iv), .icache_req_block_addr(ia), .icache_req_ready(i_rdy[1]),
    .icache_resp_valid(i_rv[1]), .icache_resp_block_data(i_rd[1]),
    .dcache_req_valid(dv), .dcache_req_type(dtype), .dcache_req_block_addr(da),
    .dcache_req_block_data(dd), .dcache_req_ready(d_rdy[1]),
    .dcache_resp_valid(d_rv[1]), .dcache_resp_block_data(d_rd[1]),
    .mem_req_valid(m_v[1]), .mem_req_type(m_t[1]), .mem_req_block_addr(m_a[1]),
    .mem_req_block_data(m_d[1]), .mem_req_ready(mready),
    .mem_resp_valid(rvalid), .mem_resp_block_data(rdata),
    .busy(bsy[1]), .owner(own[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction per instance
  bit          pend[2];     // a request has been accepted and is not finished
  bit          sent[2];     // memory has taken the request, awaiting data
  bit          last[2];     // last grantee: 0 icache, 1 dcache
  bit          ttype[2];
  logic [25:0]  taddr[2];
  logic [511:0] tdata[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0; sent[k] = 1'b0; last[k] = 1'b0; ttype[k] = 1'b0;
      taddr[k] = '0; tdata[k] = '0;
    end
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        bit gd, gi, rv;
        gd = rst_aL && !pend[k] && dv && (!iv || !last[k]);
        gi = rst_aL && !pend[k] && iv && !gd;
        rv = rst_aL && pend[k] && sent[k] && rvalid;
        chk($sformatf("m%0d_i_ready", k), i_rdy[k], gi);
        chk($sformatf("m%0d_d_ready", k), d_rdy[k], gd);
        chk($sformatf("m%0d_i_resp_valid", k), i_rv[k], rv && !last[k]);
        chk($sformatf("m%0d_d_resp_valid", k), d_rv[k], rv && last[k]);
        chk($sformatf("m%0d_mem_req_valid", k), m_v[k], pend[k] && !sent[k]);
        chk($sformatf("m%0d_busy", k), bsy[k], pend[k]);
        chk($sformatf("m%0d_owner", k), own[k], last[k]);
        if (pend[k] && !sent[k]) begin
          chk($sformatf("m%0d_mem_req_type", k), m_t[k], ttype[k]);
          chk($sformatf("m%0d_mem_req_addr", k), m_a[k], taddr[k]);
          chk($sformatf("m%0d_mem_req_data", k), m_d[k], tdata[k]);
        end
        if (rv && !last[k]) chk($sformatf("m%0d_i_resp_data", k), i_rd[k], rdata);
        if (rv && last[k])  chk($sformatf("m%0d_d_resp_data", k), d_rd[k], rdata);
        // advance the model to what the next clock edge commits
        if (!rst_aL) begin
          pend[k] = 1'b0; sent[k] = 1'b0; last[k] = 1'b0;
        end else if (gd) begin
          pend[k] = 1'b1; sent[k] = 1'b0; last[k] = 1'b1;
          ttype[k] = dtype; taddr[k] = da; tdata[k] = dd;
        end else if (gi) begin
          pend[k] = 1'b1; sent[k] = 1'b0; last[k] = 1'b0;
          ttype[k] = 1'b0; taddr[k] = ia; tdata[k] = '0;
        end else if (pend[k] && !sent[k] && mready) begin
          if (ttype[k] && k == 0) pend[k] = 1'b0;
          else sent[k] = 1'b1;
        end else if (rv) begin
          pend[k] = 1'b0; sent[k] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept already granted; issue with immediate ready, then answer the next cycle
  task automatic finish_read(input logic [511:0] d);
    mready = 1'b1; tick(); mready = 1'b0;
    rvalid = 1'b1; rdata = d; tick(); rvalid = 1'b0;
  endtask

  initial begin
    rst_aL = 1'b0; iv = 1'b0; dv = 1'b0; dtype = 1'b0; mready = 1'b0; rvalid = 1'b0;
    ia = '0; da = '0; dd = '0; rdata = '0;
    repeat (2) tick();
    rst_aL = 1'b1;
    chk("rst_busy", bsy[0], 1'b0);
    chk("rst_mem_req_valid", m_v[0], 1'b0);
    chk("rst_owner", own[0], 1'b0);
    chk("rst_mem_req_addr", m_a[0], 26'h0);
    chk("rst_mem_req_data", m_d[0], 512'h0);
    chk("rst_i_resp_data", i_rd[0], 512'h0);

    // single icache read, response three cycles after the handshake
    iv = 1'b1; ia = 26'h0000123; #1;
    chk("t1_i_ready", i_rdy[0], 1'b1);
    chk("t1_d_ready", d_rdy[0], 1'b0);
    tick(); iv = 1'b0;
    chk("t1_mem_valid", m_v[0], 1'b1);
    chk("t1_mem_addr", m_a[0], 26'h0000123);
    chk("t1_mem_type", m_t[0], 1'b0);
    mready = 1'b1; tick(); mready = 1'b0;
    tick(); tick();
    rvalid = 1'b1; rdata = {64{8'hA5}}; #1;
    chk("t1_i_resp_valid", i_rv[0], 1'b1);
    chk("t1_i_resp_data", i_rd[0], {64{8'hA5}});
    chk("t1_d_resp_valid", d_rv[0], 1'b0);
    tick(); rvalid = 1'b0;
    chk("t1_idle_after", bsy[0], 1'b0);

    // ties alternate, dcache first
    iv = 1'b1; dv = 1'b1; ia = 26'h66; da = 26'h55; #1;
    chk("t2_tie1_d_ready", d_rdy[0], 1'b1);
    chk("t2_tie1_i_ready", i_rdy[0], 1'b0);
    tick(); dv = 1'b0;
    chk("t2_owner_d", own[0], 1'b1);
    chk("t2_addr_d", m_a[0], 26'h55);
    mready = 1'b1; tick(); mready = 1'b0;
    rvalid = 1'b1; rdata = {16{32'h0123_4567}}; #1;
    chk("t2_d_resp_valid", d_rv[0], 1'b1);
    chk("t2_i_resp_quiet", i_rv[0], 1'b0);
    tick(); rvalid = 1'b0; #1;
    chk("t2_i_granted_next", i_rdy[0], 1'b1);
    tick(); iv = 1'b0;
    chk("t2_addr_i", m_a[0], 26'h66);
    chk("t2_owner_i", own[0], 1'b0);
    finish_read({16{32'h89AB_CDEF}});
    iv = 1'b1; dv = 1'b1; ia = 26'h77; da = 26'h88; #1;
    chk("t2_tie3_d_ready", d_rdy[0], 1'b1);
    tick(); iv = 1'b0; dv = 1'b0;
    finish_read({16{32'h1111_2222}});

    // dcache write: instance 0 completes on handshake, instance 1 on response
    dv = 1'b1; dtype = 1'b1; da = 26'h3FF; dd = {16{32'hDEADBEEF}};
    tick(); dv = 1'b0; dtype = 1'b0;
    chk("t3_type0", m_t[0], 1'b1);
    chk("t3_data0", m_d[0], {16{32'hDEADBEEF}});
    chk("t3_addr1", m_a[1], 26'h3FF);
    mready = 1'b1; tick(); mready = 1'b0;
    chk("t3_busy0_idle", bsy[0], 1'b0);
    chk("t3_busy1_wait", bsy[1], 1'b1);
    tick();
    rvalid = 1'b1; rdata = {16{32'h5A5A_0001}}; #1;
    chk("t3_d_resp1", d_rv[1], 1'b1);
    chk("t3_d_resp0_quiet", d_rv[0], 1'b0);
    tick(); rvalid = 1'b0;
    chk("t3_busy1_done", bsy[1], 1'b0);

    // backpressure with a dcache request arriving meanwhile and a spurious response
    iv = 1'b1; ia = 26'h2AA; tick(); iv = 1'b0;
    dv = 1'b1; da = 26'h111; dd = {16{32'hCAFE_F00D}};
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", m_v[0], 1'b1);
      chk("t4_hold_addr", m_a[0], 26'h2AA);
      chk("t4_d_not_ready", d_rdy[0], 1'b0);
      rvalid = (i == 2); tick();
    end
    rvalid = 1'b0; mready = 1'b1;
    chk("t4_valid_6th", m_v[0], 1'b1);
    tick(); mready = 1'b0;
    chk("t4_valid_dropped", m_v[0], 1'b0);
    rvalid = 1'b1; rdata = {16{32'h0F0F_0F0F}}; tick(); rvalid = 1'b0; #1;
    chk("t4_d_ready_after", d_rdy[0], 1'b1);
    tick(); dv = 1'b0;
    finish_read({16{32'h3333_4444}});

    // spurious response while idle
    rvalid = 1'b1; tick(); tick(); rvalid = 1'b0;
    chk("t5_still_idle", bsy[0], 1'b0);

    // reset during WAIT_RESP drops the dcache transaction and clears last grant
    dv = 1'b1; da = 26'h3C; tick(); dv = 1'b0;
    mready = 1'b1; tick(); mready = 1'b0;
    chk("t6_busy_wait", bsy[0], 1'b1);
    rst_aL = 1'b0; tick(); rst_aL = 1'b1;
    chk("t6_busy_reset", bsy[0], 1'b0);
    chk("t6_owner_reset", own[0], 1'b0);
    rvalid = 1'b1; tick(); rvalid = 1'b0;
    iv = 1'b1; dv = 1'b1; ia = 26'h12; da = 26'h34; #1;
    chk("t6_tie_d_ready", d_rdy[0], 1'b1);
    chk("t6_tie_i_ready", i_rdy[0], 1'b0);
    tick(); iv = 1'b0; dv = 1'b0;
    finish_read({16{32'h7777_8888}});
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
